// File: rtl/sc_game_statemachine.sv
// Frogger-style game controller: lives, crash debounce and hold, respawn sequencing, win handling.
// Define SC_GAMESTATEMACHINE_LEVELS_EN for multi-level play; otherwise a win ends the game and the level stays 0.
module sc_game_statemachine #(
    parameter int LIVES_INIT      = 3,
    parameter int HOLD_TICKS      = 4,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic       SC_GAMESTATEMACHINE_CLOCK_50,
    input  logic       SC_GAMESTATEMACHINE_RESET_InHigh,
    input  logic       SC_GAMESTATEMACHINE_crash_InLow,
    input  logic       SC_GAMESTATEMACHINE_win_InHigh,
    input  logic       SC_GAMESTATEMACHINE_start_InHigh,
    input  logic       SC_GAMESTATEMACHINE_tick_InHigh,
    output logic [2:0] SC_GAMESTATEMACHINE_state_OutBUS,
    output logic [2:0] SC_GAMESTATEMACHINE_lives_OutBUS,
    output logic [2:0] SC_GAMESTATEMACHINE_level_OutBUS,
    output logic       SC_GAMESTATEMACHINE_respawn_OutHigh,
    output logic       SC_GAMESTATEMACHINE_gameover_OutHigh,
    output logic       SC_GAMESTATEMACHINE_win_OutHigh
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_CRASH    = 3'd2,
        ST_RESPAWN  = 3'd3,
        ST_GAMEOVER = 3'd4,
        ST_WIN      = 3'd5
    } state_t;

    localparam logic [2:0] LIVES_START = 3'(LIVES_INIT);
    localparam logic [3:0] HOLD_MAX    = 4'(HOLD_TICKS);
    localparam logic [3:0] DEB_MAX     = 4'(DEBOUNCE_CYCLES);

    state_t     state_q, state_n;
    logic [2:0] lives_q, lives_n;
    logic [2:0] level_q, level_n;
    logic [3:0] deb_q, deb_n;
    logic [3:0] hold_q, hold_n;
    logic       respawn_q, gameover_q, win_q;
    logic       crash_accept;

    assign crash_accept = !SC_GAMESTATEMACHINE_crash_InLow && ((deb_q + 4'd1) >= DEB_MAX);

    always_ff @(posedge SC_GAMESTATEMACHINE_CLOCK_50) begin
        if (SC_GAMESTATEMACHINE_RESET_InHigh) begin
            state_q    <= ST_IDLE;
            lives_q    <= 3'd0;
            level_q    <= 3'd0;
            deb_q      <= 4'd0;
            hold_q     <= 4'd0;
            respawn_q  <= 1'b0;
            gameover_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            lives_q    <= lives_n;
            level_q    <= level_n;
            deb_q      <= deb_n;
            hold_q     <= hold_n;
            respawn_q  <= (state_n == ST_RESPAWN);
            gameover_q <= (state_n == ST_GAMEOVER);
            win_q      <= (state_n == ST_WIN);
        end
    end

    always_comb begin
        state_n = state_q;
        lives_n = lives_q;
        level_n = level_q;
        deb_n   = deb_q;
        hold_n  = hold_q;
        case (state_q)
            ST_IDLE, ST_GAMEOVER, ST_WIN: begin
                if (SC_GAMESTATEMACHINE_start_InHigh) begin
                    state_n = ST_RESPAWN;
                    lives_n = LIVES_START;
                    level_n = 3'd0;
                end
            end
            ST_PLAY: begin
                deb_n = SC_GAMESTATEMACHINE_crash_InLow ? 4'd0 : deb_q + 4'd1;
                // A confirmed crash takes priority over a simultaneous win.
                if (crash_accept) begin
                    state_n = ST_CRASH;
                    lives_n = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    deb_n   = 4'd0;
                    hold_n  = 4'd0;
                end else if (SC_GAMESTATEMACHINE_win_InHigh) begin
`ifdef SC_GAMESTATEMACHINE_LEVELS_EN
                    if (level_q == 3'd7) begin
                        state_n = ST_WIN;
                    end else begin
                        level_n = level_q + 3'd1;
                        state_n = ST_RESPAWN;
                    end
`else
                    state_n = ST_WIN;
`endif
                end
            end
            ST_CRASH: begin
                if (SC_GAMESTATEMACHINE_tick_InHigh) begin
                    hold_n = hold_q + 4'd1;
                    if ((hold_q + 4'd1) >= HOLD_MAX) begin
                        hold_n  = 4'd0;
                        state_n = (lives_q != 3'd0) ? ST_RESPAWN : ST_GAMEOVER;
                    end
                end
            end
            ST_RESPAWN: begin
                deb_n   = 4'd0;
                state_n = ST_PLAY;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign SC_GAMESTATEMACHINE_state_OutBUS      = state_q;
    assign SC_GAMESTATEMACHINE_lives_OutBUS      = lives_q;
`ifdef SC_GAMESTATEMACHINE_LEVELS_EN
    assign SC_GAMESTATEMACHINE_level_OutBUS      = level_q;
`else
    assign SC_GAMESTATEMACHINE_level_OutBUS      = 3'd0;
`endif
    assign SC_GAMESTATEMACHINE_respawn_OutHigh   = respawn_q;
    assign SC_GAMESTATEMACHINE_gameover_OutHigh  = gameover_q;
    assign SC_GAMESTATEMACHINE_win_OutHigh       = win_q;

endmodule

// File: tb/tb_sc_game_statemachine.sv
// Directed bench for sc_game_statemachine with default parameters.
// Covers reset, start, crash debounce/hold, game over, crash-vs-win priority, winning and reset during play.
module tb_sc_game_statemachine;

    logic       clk;
    logic       reset;
    logic       crash_n;
    logic       win_in;
    logic       start;
    logic       tick;
    logic [2:0] state;
    logic [2:0] lives;
    logic [2:0] level;
    logic       respawn;
    logic       gameover;
    logic       win_out;

    int total = 0;
    int bad   = 0;

    sc_game_statemachine dut (
        .SC_GAMESTATEMACHINE_CLOCK_50        (clk),
        .SC_GAMESTATEMACHINE_RESET_InHigh    (reset),
        .SC_GAMESTATEMACHINE_crash_InLow     (crash_n),
        .SC_GAMESTATEMACHINE_win_InHigh      (win_in),
        .SC_GAMESTATEMACHINE_start_InHigh    (start),
        .SC_GAMESTATEMACHINE_tick_InHigh     (tick),
        .SC_GAMESTATEMACHINE_state_OutBUS    (state),
        .SC_GAMESTATEMACHINE_lives_OutBUS    (lives),
        .SC_GAMESTATEMACHINE_level_OutBUS    (level),
        .SC_GAMESTATEMACHINE_respawn_OutHigh (respawn),
        .SC_GAMESTATEMACHINE_gameover_OutHigh(gameover),
        .SC_GAMESTATEMACHINE_win_OutHigh     (win_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_crash();
        crash_n = 1'b0;
        step();
        step();
        crash_n = 1'b1;
    endtask

    task automatic hold_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; crash_n = 1'b1; win_in = 1'b0; start = 1'b0; tick = 1'b0;
        step();
        step();
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        total++; if (lives !== 3'd0) begin bad++; $display("[TB] FAIL reset_lives got=%0d exp=0", lives); end
        total++; if (level !== 3'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
        total++; if ({respawn, gameover, win_out} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b exp=000", {respawn, gameover, win_out}); end
        reset = 1'b0;
        step();
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL idle_hold got=%0d exp=0", state); end
    endtask

    task automatic test_start();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL start_respawn got=%0d exp=3", state); end
        total++; if (respawn !== 1'b1) begin bad++; $display("[TB] FAIL start_pulse got=%b exp=1", respawn); end
        total++; if (lives !== 3'd3) begin bad++; $display("[TB] FAIL start_lives got=%0d exp=3", lives); end
        step();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL start_play got=%0d exp=1", state); end
        total++; if (respawn !== 1'b0) begin bad++; $display("[TB] FAIL pulse_once got=%b exp=0", respawn); end
    endtask

    task automatic test_debounce();
        crash_n = 1'b0;
        step();
        crash_n = 1'b1;
        step();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL glitch_ignored got=%0d exp=1", state); end
        crash_n = 1'b0;
        step();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL deb_one_clk got=%0d exp=1", state); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        crash_n = 1'b1;
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL crash_enter got=%0d exp=2", state); end
        total++; if (lives !== 3'd2) begin bad++; $display("[TB] FAIL crash_lives got=%0d exp=2", lives); end
        hold_ticks(3);
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL hold_3_ticks got=%0d exp=2", state); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL hold_done got=%0d exp=3", state); end
        total++; if (respawn !== 1'b1) begin bad++; $display("[TB] FAIL crash_respawn got=%b exp=1", respawn); end
        step();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL back_to_play got=%0d exp=1", state); end
    endtask

    task automatic test_gameover();
        accept_crash();
        hold_ticks(4);
        total++; if (lives !== 3'd1) begin bad++; $display("[TB] FAIL second_crash_lives got=%0d exp=1", lives); end
        accept_crash();
        total++; if (lives !== 3'd0) begin bad++; $display("[TB] FAIL third_crash_lives got=%0d exp=0", lives); end
        hold_ticks(4);
        total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL gameover_state got=%0d exp=4", state); end
        total++; if (gameover !== 1'b1) begin bad++; $display("[TB] FAIL gameover_flag got=%b exp=1", gameover); end
        crash_n = 1'b0; win_in = 1'b1; tick = 1'b1;
        step();
        step();
        crash_n = 1'b1; win_in = 1'b0; tick = 1'b0;
        total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL gameover_sticky got=%0d exp=4", state); end
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL restart_respawn got=%0d exp=3", state); end
        total++; if (lives !== 3'd3) begin bad++; $display("[TB] FAIL restart_lives got=%0d exp=3", lives); end
        total++; if (gameover !== 1'b0) begin bad++; $display("[TB] FAIL restart_gameover got=%b exp=0", gameover); end
        step();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL restart_play got=%0d exp=1", state); end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (state !== 3'd1 || respawn !== 1'b0) begin bad++; $display("[TB] FAIL start_in_play got=%0d/%b exp=1/0", state, respawn); end
        accept_crash();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL start_in_crash got=%0d exp=2", state); end
        total++; if (lives !== 3'd2) begin bad++; $display("[TB] FAIL start_in_crash_lives got=%0d exp=2", lives); end
        hold_ticks(4);
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL resume_play got=%0d exp=1", state); end
    endtask

    task automatic test_crash_and_win();
        crash_n = 1'b0;
        step();
        win_in = 1'b1;
        step();
        crash_n = 1'b1;
        win_in = 1'b0;
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL crash_beats_win got=%0d exp=2", state); end
        total++; if (level !== 3'd0) begin bad++; $display("[TB] FAIL crash_win_level got=%0d exp=0", level); end
        total++; if (win_out !== 1'b0) begin bad++; $display("[TB] FAIL crash_win_flag got=%b exp=0", win_out); end
        total++; if (lives !== 3'd1) begin bad++; $display("[TB] FAIL crash_win_lives got=%0d exp=1", lives); end
    endtask

    task automatic test_reset_mid_crash();
        hold_ticks(2);
        reset = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL midcrash_state got=%0d exp=0", state); end
        total++; if (lives !== 3'd0) begin bad++; $display("[TB] FAIL midcrash_lives got=%0d exp=0", lives); end
        total++; if ({respawn, gameover, win_out} !== 3'b000) begin bad++; $display("[TB] FAIL midcrash_flags got=%b exp=000", {respawn, gameover, win_out}); end
        reset = 1'b0;
        step();
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL post_reset_idle got=%0d exp=0", state); end
    endtask

    task automatic test_win();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL win_setup got=%0d exp=1", state); end
`ifdef SC_GAMESTATEMACHINE_LEVELS_EN
        for (int i = 1; i <= 7; i++) begin
            win_in = 1'b1;
            step();
            win_in = 1'b0;
            total++; if (state !== 3'd3 || level !== 3'(i)) begin bad++; $display("[TB] FAIL level_up got=%0d/%0d exp=3/%0d", state, level, i); end
            step();
        end
        win_in = 1'b1;
        step();
        win_in = 1'b0;
        total++; if (state !== 3'd5 || level !== 3'd7) begin bad++; $display("[TB] FAIL final_win got=%0d/%0d exp=5/7", state, level); end
`else
        win_in = 1'b1;
        step();
        win_in = 1'b0;
        total++; if (state !== 3'd5 || level !== 3'd0) begin bad++; $display("[TB] FAIL direct_win got=%0d/%0d exp=5/0", state, level); end
`endif
        total++; if (win_out !== 1'b1) begin bad++; $display("[TB] FAIL win_flag got=%b exp=1", win_out); end
        crash_n = 1'b0; tick = 1'b1;
        step();
        step();
        crash_n = 1'b1; tick = 1'b0;
        total++; if (state !== 3'd5) begin bad++; $display("[TB] FAIL win_sticky got=%0d exp=5", state); end
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (state !== 3'd3 || level !== 3'd0 || lives !== 3'd3) begin bad++; $display("[TB] FAIL win_restart got=%0d/%0d/%0d exp=3/0/3", state, level, lives); end
        total++; if (win_out !== 1'b0) begin bad++; $display("[TB] FAIL win_restart_flag got=%b exp=0", win_out); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (state !== 3'd0 || respawn !== 1'b0) begin bad++; $display("[TB] FAIL reset_mid_respawn got=%0d/%b exp=0/0", state, respawn); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_debounce();
        test_gameover();
        test_start_ignored();
        test_crash_and_win();
        test_reset_mid_crash();
        test_win();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
